key_conditioner: RTL and testbench
==================================

# key_conditioner

Conditions the two raw front-panel keys that step the ROM address, and sits directly upstream of `rom_reader`. It synchronises and debounces each key, then drives clean `increment_address` and `decrement_address` levels. It arbitrates simultaneous presses and adds hold-to-repeat, so a held key produces a train of press/release cycles, each of which steps the reader by one address.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a key change (≥2).
- `REPEAT_DELAY_CYCLES`, 25000000: high time of the first press before auto-repeat starts (≥2).
- `REPEAT_PERIOD_CYCLES`, 5000000: high time of each repeated press (≥2).
- `REPEAT_GAP_CYCLES`, 4: low time between repeated presses (≥2).
- `KEY_ACTIVE_LOW`, 1: 1 means a raw key reads 0 when pressed.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `key_inc_raw` in 1: raw increment key, asynchronous to `clk`.
- `key_dec_raw` in 1: raw decrement key, asynchronous to `clk`.
- `increment_address` out 1: registered level to `rom_reader`.
- `decrement_address` out 1: registered level to `rom_reader`.
- `key_inc_stable` out 1: debounced increment key, 1 = pressed.
- `key_dec_stable` out 1: debounced decrement key, 1 = pressed.
- `repeat_active` out 1: 1 while the current press is in auto-repeat.

## Operation
- **Synchroniser:** 2-FF per key, followed by inversion when `KEY_ACTIVE_LOW`=1. Synchroniser FFs reset to the not-pressed level.
- **Debounce (per key):**
  - The counter increments while the synced value ≠ stable value, and clears to 0 on any cycle where they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1, the stable value takes the synced value and the counter clears.
  - Counter and timer widths are `$clog2(param+1)`. There is no wrap: counts saturate at the terminal value by construction.
- **Arbiter FSM:** states IDLE, INC_ON, INC_GAP, DEC_ON, DEC_GAP, LOCKOUT. A shared timer clears on every state entry.
  - IDLE: both outputs 0, `repeat_active`=0. Transitions:
    - inc only → INC_ON.
    - dec only → DEC_ON.
    - both → LOCKOUT.
  - INC_ON: `increment_address`=1. Transitions are checked in this priority:
    - `key_dec_stable` → LOCKOUT.
    - inc released → IDLE. The output falls, so `rom_reader` counts one step.
    - timer = limit-1 → INC_GAP, with `repeat_active`←1. The limit is `REPEAT_DELAY_CYCLES` when `repeat_active`=0, else `REPEAT_PERIOD_CYCLES`.
  - INC_GAP: `increment_address`=0. When timer = `REPEAT_GAP_CYCLES`-1:
    - inc only → INC_ON.
    - dec pressed → LOCKOUT.
    - inc released → IDLE.
  - DEC_ON and DEC_GAP mirror INC_ON and INC_GAP, with the keys swapped.
  - LOCKOUT: both outputs 0, `repeat_active`=0. Leaves to IDLE only when both stable keys are 0. This guarantees the two outputs are never 1 together and no step is taken on a conflicting press.
- A release during a GAP is sampled only at gap end. The release itself produces no extra step, because the output is already low.

## Timing
- Reset values:
  - All outputs 0.
  - Stable values 0.
  - Counters and timers 0.
  - State IDLE.
  - Reset is asynchronous: outputs go to 0 immediately on `reset_n` falling, regardless of key state.
- Latency from a raw edge to its stable output: 2 sync cycles + `DEBOUNCE_CYCLES` cycles, assuming a clean edge.
- Stable → `increment_address`/`decrement_address`: 1 cycle, registered.
- First press high time: `REPEAT_DELAY_CYCLES` cycles. Each repeat: `REPEAT_GAP_CYCLES` low, then `REPEAT_PERIOD_CYCLES` high.
- `REPEAT_GAP_CYCLES` ≥2 guarantees that `rom_reader` observes the low level, and completes its off state, before the next rise.
- Reset mid-repeat: the FSM returns to IDLE. A key still held after reset releases is treated as a fresh press once debounced.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY_CYCLES`=20, `REPEAT_PERIOD_CYCLES`=8, `REPEAT_GAP_CYCLES`=2, `KEY_ACTIVE_LOW`=1.

1. **Reset:** hold `reset_n`=0 with both raw keys at 0 (pressed) → all outputs stay 0. Release reset → `key_inc_stable` and `key_dec_stable` rise at cycle 6, then the FSM enters LOCKOUT with both address outputs 0.
2. **Bounce:** toggle `key_inc_raw` every 2 cycles for 12 cycles, then hold it at 0 for 15 cycles, then at 1 → required response:
   - `key_inc_stable` rises exactly 6 cycles after the last edge.
   - `increment_address` rises 1 cycle later and falls 7 cycles after release.
   - Exactly one high pulse.
3. **Glitch:** drive `key_dec_raw` to 0 for 3 cycles → `key_dec_stable` and `decrement_address` never assert.
4. **Auto-repeat:** hold inc for 60 cycles after `key_inc_stable` rises → required response:
   - `increment_address` is high 20 cycles, then alternates low 2 / high 8.
   - `repeat_active` rises at the first gap.
   - A `rom_reader` model advances once per falling edge of `increment_address`.
5. **Conflict:** while inc is held in INC_ON, press dec → `increment_address` falls to 0 within 1 cycle of `key_dec_stable` rising, and `decrement_address` stays 0. Then release both and press dec alone → exactly one dec pulse, with outputs never both 1.
6. **Reset mid-repeat:** drop `reset_n` during an INC_ON repeat phase → `increment_address` and `repeat_active` go to 0 asynchronously. After reset releases with inc still held, the next press starts a fresh 20-cycle first high time.

Source files
------------

// File: rtl/key_conditioner_if.sv
// Key path bundle between the front-panel keys and the conditioner.
// The panel side (master) drives the raw keys; the conditioner (slave) drives the clean levels.
interface key_conditioner_if;
    logic key_inc_raw;
    logic key_dec_raw;
    logic increment_address;
    logic decrement_address;
    logic key_inc_stable;
    logic key_dec_stable;
    logic repeat_active;

    modport master (
        output key_inc_raw,
        output key_dec_raw,
        input  increment_address,
        input  decrement_address,
        input  key_inc_stable,
        input  key_dec_stable,
        input  repeat_active
    );

    modport slave (
        input  key_inc_raw,
        input  key_dec_raw,
        output increment_address,
        output decrement_address,
        output key_inc_stable,
        output key_dec_stable,
        output repeat_active
    );
endinterface

// File: rtl/key_conditioner.sv
// Synchronises, debounces and arbitrates the two address-step keys, with hold-to-repeat,
// producing clean increment/decrement levels for rom_reader.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no key accepted, both outputs low
// INC_ON  | increment_address high (first press or repeat high time)
// INC_GAP | increment_address low between repeated increments
// DEC_ON  | decrement_address high (first press or repeat high time)
// DEC_GAP | decrement_address low between repeated decrements
// LOCKOUT | conflicting keys seen, wait until both are released
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 50000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter int REPEAT_GAP_CYCLES    = 4,
    parameter int KEY_ACTIVE_LOW       = 1
) (
    input logic              clk,
    input logic              reset_n,
    key_conditioner_if.slave kc
);
    localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX_DP = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int TMAX    = (TMAX_DP > REPEAT_GAP_CYCLES) ? TMAX_DP : REPEAT_GAP_CYCLES;
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [DBW-1:0] DEB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  DELAY_LAST  = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0]  PERIOD_LAST = TW'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic [TW-1:0]  GAP_LAST    = TW'(REPEAT_GAP_CYCLES - 1);
    localparam logic           RAW_IDLE    = (KEY_ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        IDLE,
        INC_ON,
        INC_GAP,
        DEC_ON,
        DEC_GAP,
        LOCKOUT
    } state_t;

    // bit 0 = increment key, bit 1 = decrement key
    logic [1:0]          sync1;
    logic [1:0]          sync2;
    logic [1:0]          synced;
    logic [1:0]          key_stable;
    logic [1:0][DBW-1:0] deb_cnt;

    state_t         state;
    state_t         state_nxt;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_nxt;
    logic [TW-1:0]  on_last;
    logic           rpt_q;
    logic           rpt_nxt;
    logic           inc_addr_q;
    logic           dec_addr_q;
    logic           inc_st;
    logic           dec_st;

    assign synced = sync2 ^ {2{RAW_IDLE}};
    assign inc_st = key_stable[0];
    assign dec_st = key_stable[1];

    // Sync FFs reset to the released level so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= {2{RAW_IDLE}};
            sync2      <= {2{RAW_IDLE}};
            key_stable <= '0;
            deb_cnt    <= '0;
        end else begin
            sync1 <= {kc.key_dec_raw, kc.key_inc_raw};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (synced[i] == key_stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    key_stable[i] <= synced[i];
                    deb_cnt[i]    <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign on_last = rpt_q ? PERIOD_LAST : DELAY_LAST;

    always_comb begin
        state_nxt = state;
        rpt_nxt   = rpt_q;
        timer_nxt = '0;
        case (state)
            IDLE: begin
                if (inc_st && dec_st)  state_nxt = LOCKOUT;
                else if (inc_st)       state_nxt = INC_ON;
                else if (dec_st)       state_nxt = DEC_ON;
            end
            INC_ON: begin
                if (dec_st)                state_nxt = IDLE == IDLE ? LOCKOUT : LOCKOUT;
                else if (!inc_st)          state_nxt = IDLE;
                else if (timer == on_last) begin
                    state_nxt = INC_GAP;
                    rpt_nxt   = 1'b1;
                end
            end
            INC_GAP: begin
                if (timer == GAP_LAST) begin
                    if (dec_st)       state_nxt = LOCKOUT;
                    else if (!inc_st) state_nxt = IDLE;
                    else              state_nxt = INC_ON;
                end
            end
            DEC_ON: begin
                if (inc_st)                state_nxt = LOCKOUT;
                else if (!dec_st)          state_nxt = IDLE;
                else if (timer == on_last) begin
                    state_nxt = DEC_GAP;
                    rpt_nxt   = 1'b1;
                end
            end
            DEC_GAP: begin
                if (timer == GAP_LAST) begin
                    if (inc_st)       state_nxt = LOCKOUT;
                    else if (!dec_st) state_nxt = IDLE;
                    else              state_nxt = DEC_ON;
                end
            end
            LOCKOUT: begin
                if (!inc_st && !dec_st) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE || state_nxt == LOCKOUT) rpt_nxt = 1'b0;

        // Timer restarts on every state entry and only runs in the timed states.
        if (state_nxt == state &&
            (state == INC_ON || state == INC_GAP || state == DEC_ON || state == DEC_GAP))
            timer_nxt = timer + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            rpt_q      <= 1'b0;
            inc_addr_q <= 1'b0;
            dec_addr_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            rpt_q      <= rpt_nxt;
            inc_addr_q <= (state_nxt == INC_ON);
            dec_addr_q <= (state_nxt == DEC_ON);
        end
    end

    assign kc.increment_address = inc_addr_q;
    assign kc.decrement_address = dec_addr_q;
    assign kc.key_inc_stable    = inc_st;
    assign kc.key_dec_stable    = dec_st;
    assign kc.repeat_active     = rpt_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: a table of single-key presses plus hand-written reset,
// bounce, conflict and reset-mid-repeat sequences, checked against an event scoreboard.
module tb_key_conditioner;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int GAP = 2;
    localparam int NV  = 8;

    typedef struct {
        int cyc;
        int sig;
        bit val;
    } ev_t;

    typedef struct {
        bit is_dec;
        int hold;
        int exp_steps;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    key_conditioner_if kif();

    key_conditioner #(
        .DEBOUNCE_CYCLES     (DEB),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_PERIOD_CYCLES(RP),
        .REPEAT_GAP_CYCLES   (GAP),
        .KEY_ACTIVE_LOW      (1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .kc     (kif)
    );

    always #5 clk = ~clk;

    ev_t        exp_q[$];
    vec_t       vecs[NV];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         inc_steps = 0;
    int         dec_steps = 0;
    int         both_hi = 0;
    logic [4:0] prev = '0;

    // Signal ids: 0 increment_address, 1 decrement_address, 2 inc stable, 3 dec stable, 4 repeat_active
    function automatic logic [4:0] snap();
        return {kif.repeat_active, kif.key_dec_stable, kif.key_inc_stable,
                kif.decrement_address, kif.increment_address};
    endfunction

    task automatic push_ev(input int sig, input bit val, input int c);
        ev_t e;
        int  pos;
        e.cyc = c;
        e.sig = sig;
        e.val = val;
        pos = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc * 8 + exp_q[i].sig > c * 8 + sig) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, e);
    endtask

    // Expected timeline of a clean press driven at cycle t0 and released at t0+h.
    task automatic push_press(input bit is_dec, input int t0, input int h);
        int so;
        int ss;
        int s;
        int rise;
        int dur;
        int fall;
        bit rpt;
        if (h < DEB) return;
        so = is_dec ? 1 : 0;
        ss = is_dec ? 3 : 2;
        s  = t0 + h + DEB + 2;
        push_ev(ss, 1'b1, t0 + DEB + 2);
        push_ev(ss, 1'b0, s);
        rise = t0 + DEB + 3;
        dur  = RD;
        rpt  = 1'b0;
        forever begin
            push_ev(so, 1'b1, rise);
            fall = rise + dur;
            if (s + 1 <= fall) begin
                push_ev(so, 1'b0, s + 1);
                if (rpt) push_ev(4, 1'b0, s + 1);
                break;
            end
            push_ev(so, 1'b0, fall);
            if (!rpt) begin
                push_ev(4, 1'b1, fall);
                rpt = 1'b1;
            end
            if (s <= fall + GAP - 1) begin
                push_ev(4, 1'b0, fall + GAP);
                break;
            end
            rise = fall + GAP;
            dur  = RP;
        end
    endtask

    task automatic monitor();
        logic [4:0] cur;
        ev_t        e;
        cur = snap();
        if (cur[0] && cur[1]) both_hi++;
        if (prev[0] && !cur[0]) inc_steps++;
        if (prev[1] && !cur[1]) dec_steps++;
        for (int s = 0; s < 5; s++) begin
            if (cur[s] != prev[s]) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL event sig%0d: got %0b at cycle %0d, required no change",
                             s, cur[s], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.sig != s || e.val != cur[s] || e.cyc != cyc) begin
                        fails++;
                        $display("FAIL event: got sig%0d=%0b at cycle %0d, required sig%0d=%0b at cycle %0d",
                                 s, cur[s], cyc, e.sig, e.val, e.cyc);
                    end
                end
            end
        end
        prev = cur;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #2;
            monitor();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s missing events: %0d left, first sig%0d=%0b at cycle %0d",
                     name, exp_q.size(), exp_q[0].sig, exp_q[0].val, exp_q[0].cyc);
        end
        exp_q.delete();
    endtask

    initial begin
        int t;
        int m;
        int rc;
        int n0;

        vecs[0] = '{1'b0, 15, 1};
        vecs[1] = '{1'b1, 3, 0};
        vecs[2] = '{1'b1, 12, 1};
        vecs[3] = '{1'b0, 20, 1};
        vecs[4] = '{1'b0, 22, 1};
        vecs[5] = '{1'b0, 23, 2};
        vecs[6] = '{1'b0, 66, 6};
        vecs[7] = '{1'b1, 33, 3};

        // Reset with both keys pressed: nothing may assert until debounce completes.
        reset_n         = 1'b1;
        kif.key_inc_raw = 1'b0;
        kif.key_dec_raw = 1'b0;
        #1 reset_n = 1'b0;
        tick(4);
        chk("reset increment_address", int'(kif.increment_address), 0);
        chk("reset decrement_address", int'(kif.decrement_address), 0);
        chk("reset key_inc_stable", int'(kif.key_inc_stable), 0);
        chk("reset key_dec_stable", int'(kif.key_dec_stable), 0);
        chk("reset repeat_active", int'(kif.repeat_active), 0);
        m = cyc;
        reset_n = 1'b1;
        push_ev(2, 1'b1, m + 6);
        push_ev(3, 1'b1, m + 6);
        tick(10);
        chk("lockout increment_address", int'(kif.increment_address), 0);
        chk("lockout decrement_address", int'(kif.decrement_address), 0);
        t = cyc;
        kif.key_inc_raw = 1'b1;
        kif.key_dec_raw = 1'b1;
        push_ev(2, 1'b0, t + 6);
        push_ev(3, 1'b0, t + 6);
        tick(12);
        drain("reset");

        // Bounce then a clean 15-cycle hold.
        for (int i = 0; i < 3; i++) begin
            kif.key_inc_raw = 1'b0;
            tick(2);
            kif.key_inc_raw = 1'b1;
            tick(2);
        end
        t  = cyc;
        n0 = inc_steps;
        kif.key_inc_raw = 1'b0;
        push_press(1'b0, t, 15);
        tick(15);
        kif.key_inc_raw = 1'b1;
        tick(20);
        drain("bounce");
        chk("bounce steps", inc_steps - n0, 1);

        for (int v = 0; v < NV; v++) begin
            t  = cyc;
            n0 = vecs[v].is_dec ? dec_steps : inc_steps;
            if (vecs[v].is_dec) kif.key_dec_raw = 1'b0;
            else                kif.key_inc_raw = 1'b0;
            push_press(vecs[v].is_dec, t, vecs[v].hold);
            tick(vecs[v].hold);
            kif.key_inc_raw = 1'b1;
            kif.key_dec_raw = 1'b1;
            tick(25);
            drain($sformatf("vec%0d", v));
            chk($sformatf("vec%0d steps", v),
                (vecs[v].is_dec ? dec_steps : inc_steps) - n0, vecs[v].exp_steps);
        end

        // Conflict: dec pressed while inc is in its first high time.
        t = cyc;
        kif.key_inc_raw = 1'b0;
        push_ev(2, 1'b1, t + 6);
        push_ev(0, 1'b1, t + 7);
        tick(10);
        n0 = dec_steps;
        kif.key_dec_raw = 1'b0;
        push_ev(3, 1'b1, t + 16);
        push_ev(0, 1'b0, t + 17);
        tick(7);
        chk("conflict increment_address", int'(kif.increment_address), 0);
        chk("conflict decrement_address", int'(kif.decrement_address), 0);
        tick(3);
        kif.key_inc_raw = 1'b1;
        kif.key_dec_raw = 1'b1;
        push_ev(2, 1'b0, t + 26);
        push_ev(3, 1'b0, t + 26);
        tick(12);
        drain("conflict");
        chk("conflict dec steps", dec_steps - n0, 0);
        t  = cyc;
        n0 = dec_steps;
        kif.key_dec_raw = 1'b0;
        push_press(1'b1, t, 12);
        tick(12);
        kif.key_dec_raw = 1'b1;
        tick(20);
        drain("dec after conflict");
        chk("dec after conflict steps", dec_steps - n0, 1);

        // Reset during the first repeat high phase, key still held afterwards.
        t = cyc;
        kif.key_inc_raw = 1'b0;
        push_ev(2, 1'b1, t + 6);
        push_ev(0, 1'b1, t + 7);
        push_ev(0, 1'b0, t + 27);
        push_ev(4, 1'b1, t + 27);
        push_ev(0, 1'b1, t + 29);
        tick(32);
        rc = cyc;
        reset_n = 1'b0;
        #1;
        chk("async reset increment_address", int'(kif.increment_address), 0);
        chk("async reset repeat_active", int'(kif.repeat_active), 0);
        push_ev(0, 1'b0, rc + 1);
        push_ev(2, 1'b0, rc + 1);
        push_ev(4, 1'b0, rc + 1);
        tick(3);
        m = cyc;
        reset_n = 1'b1;
        push_press(1'b0, m, 24);
        tick(24);
        kif.key_inc_raw = 1'b1;
        tick(25);
        drain("reset mid-repeat");

        chk("outputs never both high", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
